// File: rtl/eth_header_rx_vlan_if.sv
// Byte-stream in, header channel out, payload byte-stream out.
// The design uses the slave modport. The environment that feeds frames and
// consumes headers and payload uses the master modport.
interface eth_header_rx_vlan_if;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;

    logic        m_hdr_valid;
    logic        m_hdr_ready;
    logic [47:0] m_hdr_dest_mac;
    logic [47:0] m_hdr_src_mac;
    logic [15:0] m_hdr_eth_type;
    logic        m_hdr_vlan_present;
    logic [15:0] m_hdr_vlan_tci;

    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_hdr_ready, m_axis_tready,
        output s_axis_tready, m_hdr_valid, m_hdr_dest_mac, m_hdr_src_mac, m_hdr_eth_type,
               m_hdr_vlan_present, m_hdr_vlan_tci, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_hdr_ready, m_axis_tready,
        input  s_axis_tready, m_hdr_valid, m_hdr_dest_mac, m_hdr_src_mac, m_hdr_eth_type,
               m_hdr_vlan_present, m_hdr_vlan_tci, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/eth_header_rx_vlan.sv
// Receive Ethernet header parser with an optional single 802.1Q tag.
// It strips dest/src MAC and EtherType into a header channel. The rest of the
// frame goes out through a one-entry payload register.
module eth_header_rx_vlan #(
    parameter bit          VLAN_ENABLE = 1'b1,
    parameter logic [15:0] VLAN_TPID   = 16'h8100
) (
    input  logic              clk,
    input  logic              rst,
    eth_header_rx_vlan_if.slave bus,
    output logic              err_short
);
    localparam logic [1:0] ST_HDR     = 2'd0;
    localparam logic [1:0] ST_TAG     = 2'd1;
    localparam logic [1:0] ST_HDR_OUT = 2'd2;
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

    logic [1:0]  state;
    logic [4:0]  idx;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [15:0] vlan_tci;
    logic        vlan_present;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        s_ready;
    logic        s_fire;
    logic [15:0] type_next;

    // Header bytes always flow. Payload flows only when the output register frees up.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_HDR, ST_TAG: s_ready = 1'b1;
            ST_PAYLOAD:     s_ready = !out_valid || bus.m_axis_tready;
            default:        s_ready = 1'b0;
        endcase
    end

    assign s_fire    = bus.s_axis_tvalid && s_ready;
    // Value eth_type takes once the current byte is shifted in. The TPID check is made on it.
    assign type_next = {eth_type[7:0], bus.s_axis_tdata};

    // Header parse FSM. A tlast inside the header drops the frame and flags it as short.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HDR;
            idx          <= 5'd0;
            dest_mac     <= 48'd0;
            src_mac      <= 48'd0;
            eth_type     <= 16'd0;
            vlan_tci     <= 16'd0;
            vlan_present <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            err_short <= 1'b0;
            case (state)
                ST_HDR: if (s_fire) begin
                    idx <= idx + 5'd1;
                    if (idx < 5'd6)       dest_mac <= {dest_mac[39:0], bus.s_axis_tdata};
                    else if (idx < 5'd12) src_mac  <= {src_mac[39:0], bus.s_axis_tdata};
                    else                  eth_type <= type_next;
                    if (bus.s_axis_tlast) begin
                        idx          <= 5'd0;
                        err_short    <= 1'b1;
                        vlan_present <= 1'b0;
                        vlan_tci     <= 16'd0;
                    end else if (idx == 5'd13) begin
                        if (VLAN_ENABLE && type_next == VLAN_TPID) begin
                            state        <= ST_TAG;
                            vlan_present <= 1'b1;
                        end else begin
                            state <= ST_HDR_OUT;
                        end
                    end
                end
                ST_TAG: if (s_fire) begin
                    idx <= idx + 5'd1;
                    if (idx < 5'd16) vlan_tci <= {vlan_tci[7:0], bus.s_axis_tdata};
                    else             eth_type <= type_next;
                    if (bus.s_axis_tlast) begin
                        state        <= ST_HDR;
                        idx          <= 5'd0;
                        err_short    <= 1'b1;
                        vlan_present <= 1'b0;
                        vlan_tci     <= 16'd0;
                    end else if (idx == 5'd17) begin
                        state <= ST_HDR_OUT;
                    end
                end
                ST_HDR_OUT: if (bus.m_hdr_ready) state <= ST_PAYLOAD;
                default: if (s_fire && bus.s_axis_tlast) begin
                    state        <= ST_HDR;
                    idx          <= 5'd0;
                    vlan_present <= 1'b0;
                    vlan_tci     <= 16'd0;
                end
            endcase
        end
    end

    // One-entry payload register. It keeps draining after the FSM has moved on to the next header.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
        end else if (state == ST_PAYLOAD && s_fire) begin
            out_valid <= 1'b1;
            out_data  <= bus.s_axis_tdata;
            out_last  <= bus.s_axis_tlast;
        end else if (bus.m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.s_axis_tready      = s_ready;
    assign bus.m_hdr_valid        = (state == ST_HDR_OUT);
    assign bus.m_hdr_dest_mac     = dest_mac;
    assign bus.m_hdr_src_mac      = src_mac;
    assign bus.m_hdr_eth_type     = eth_type;
    assign bus.m_hdr_vlan_present = vlan_present;
    assign bus.m_hdr_vlan_tci     = vlan_tci;
    assign bus.m_axis_tdata       = out_data;
    assign bus.m_axis_tvalid      = out_valid;
    assign bus.m_axis_tlast       = out_last;
endmodule

// File: tb/tb_eth_header_rx_vlan.sv
// Bench for eth_header_rx_vlan. It uses two instances: one with VLAN parsing on
// and one with it off. A shared driver sends table and random frames. A
// scoreboard queue holds the expected headers and payload bytes, and a monitor
// compares each handshake against that queue.
module tb_eth_header_rx_vlan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_header_rx_vlan_if if0 ();
    eth_header_rx_vlan_if if1 ();
    logic err0, err1;

    eth_header_rx_vlan #(.VLAN_ENABLE(1'b1), .VLAN_TPID(16'h8100)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .err_short(err0));
    eth_header_rx_vlan #(.VLAN_ENABLE(1'b0), .VLAN_TPID(16'h8100)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .err_short(err1));

    logic       sel = 1'b0;
    logic [7:0] tdata = 8'd0;
    logic       tvalid = 1'b0, tlast = 1'b0;
    logic       hdr_rdy = 1'b1, man_ax_rdy = 1'b1, rnd_ax_rdy = 1'b1, rnd = 1'b0;
    logic       ax_rdy;
    assign ax_rdy = rnd ? rnd_ax_rdy : man_ax_rdy;

    assign if0.s_axis_tdata  = tdata;
    assign if0.s_axis_tlast  = tlast;
    assign if0.s_axis_tvalid = tvalid & ~sel;
    assign if0.m_hdr_ready   = hdr_rdy;
    assign if0.m_axis_tready = ax_rdy;
    assign if1.s_axis_tdata  = tdata;
    assign if1.s_axis_tlast  = tlast;
    assign if1.s_axis_tvalid = tvalid & sel;
    assign if1.m_hdr_ready   = hdr_rdy;
    assign if1.m_axis_tready = ax_rdy;

    logic s_rdy, hv, vp, axv, axl, err;
    logic [47:0] hd, hs;
    logic [15:0] ht, htci;
    logic [7:0] axd;
    assign s_rdy = sel ? if1.s_axis_tready      : if0.s_axis_tready;
    assign hv    = sel ? if1.m_hdr_valid        : if0.m_hdr_valid;
    assign hd    = sel ? if1.m_hdr_dest_mac     : if0.m_hdr_dest_mac;
    assign hs    = sel ? if1.m_hdr_src_mac      : if0.m_hdr_src_mac;
    assign ht    = sel ? if1.m_hdr_eth_type     : if0.m_hdr_eth_type;
    assign vp    = sel ? if1.m_hdr_vlan_present : if0.m_hdr_vlan_present;
    assign htci  = sel ? if1.m_hdr_vlan_tci     : if0.m_hdr_vlan_tci;
    assign axd   = sel ? if1.m_axis_tdata       : if0.m_axis_tdata;
    assign axv   = sel ? if1.m_axis_tvalid      : if0.m_axis_tvalid;
    assign axl   = sel ? if1.m_axis_tlast       : if0.m_axis_tlast;
    assign err   = sel ? err1                   : err0;

    typedef struct {
        logic [47:0] dst, src;
        logic [15:0] t12;
        bit          tag;
        logic [15:0] tci, inner;
        int          plen;
        logic [7:0]  seed;
        int          trunc;
        bit          en;
        logic [15:0] x_type;
        bit          x_vlan;
        logic [15:0] x_tci;
        bit          x_short;
    } vec_t;
    typedef struct { logic [47:0] dst, src; logic [15:0] typ, tci; bit vlan; int fid; } hdr_t;
    typedef struct { logic [7:0] d; bit last; int fid; } pay_t;

    hdr_t hq[$];
    pay_t pq[$];
    logic [7:0] fb[$];
    int nchk = 0, nfail = 0, err_cnt = 0, short_exp = 0;
    int fid_next = 0, hdr_fid_done = -1, cyc = 0, t_first = 0, t_last = 0;
    bit mon_off = 1'b0;
    hdr_t mh;
    pay_t mp;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_ax_rdy = 1'($urandom_range(1, 0));
    end

    // The monitor samples at negedge. A valid&&ready seen here is taken as a transfer on the next rising edge.
    always @(negedge clk) begin
        if (!rst && !mon_off) begin
            if (err) err_cnt = err_cnt + 1;
            if (hv && hdr_rdy) begin
                nchk = nchk + 1;
                if (hq.size() == 0) begin
                    nfail = nfail + 1;
                    $display("FAIL hdr_unexpected: got type %h tci %h, none expected", ht, htci);
                end else begin
                    mh = hq.pop_front();
                    if ({hd, hs, ht, vp, htci} !== {mh.dst, mh.src, mh.typ, mh.vlan, mh.tci}) begin
                        nfail = nfail + 1;
                        $display("FAIL hdr_fields: got %h %h %h v%0d %h expected %h %h %h v%0d %h",
                                 hd, hs, ht, vp, htci, mh.dst, mh.src, mh.typ, mh.vlan, mh.tci);
                    end
                    hdr_fid_done = mh.fid;
                end
            end
            if (axv && ax_rdy) begin
                nchk = nchk + 1;
                if (pq.size() == 0) begin
                    nfail = nfail + 1;
                    $display("FAIL payload_unexpected: got %h last %0d", axd, axl);
                end else begin
                    mp = pq.pop_front();
                    if ({axd, axl} !== {mp.d, mp.last} || mp.fid > hdr_fid_done) begin
                        nfail = nfail + 1;
                        $display("FAIL payload_byte: got %h last %0d (hdr %0d) expected %h last %0d (frame %0d)",
                                 axd, axl, hdr_fid_done, mp.d, mp.last, mp.fid);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk = nchk + 1;
        if (act !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [47:0] dst, logic [47:0] src, logic [15:0] t12, bit tag,
                                logic [15:0] tci, logic [15:0] inner, int plen, logic [7:0] seed,
                                int trunc, bit en, logic [15:0] xt, bit xv, logic [15:0] xtci, bit xs);
        vec_t v;
        v.dst = dst; v.src = src; v.t12 = t12; v.tag = tag; v.tci = tci; v.inner = inner;
        v.plen = plen; v.seed = seed; v.trunc = trunc; v.en = en;
        v.x_type = xt; v.x_vlan = xv; v.x_tci = xtci; v.x_short = xs;
        return v;
    endfunction

    task automatic build(input vec_t v);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(v.dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(v.src[47-8*i -: 8]);
        fb.push_back(v.t12[15:8]); fb.push_back(v.t12[7:0]);
        if (v.tag) begin
            fb.push_back(v.tci[15:8]);   fb.push_back(v.tci[7:0]);
            fb.push_back(v.inner[15:8]); fb.push_back(v.inner[7:0]);
        end
        for (int i = 0; i < v.plen; i++) fb.push_back(8'(v.seed * (i + 1)));
        if (v.trunc > 0) while (fb.size() > v.trunc) void'(fb.pop_back());
    endtask

    // Table entries carry their own expected header. Random frames are predicted from the frame bytes.
    task automatic push_exp(input vec_t v, input bit tbl);
        hdr_t h;
        pay_t p;
        bit sh, tg;
        int hl;
        if (tbl) begin
            sh = v.x_short; tg = v.x_vlan; h.typ = v.x_type; h.tci = v.x_tci;
        end else begin
            tg = v.en && ({fb[12], fb[13]} == 16'h8100);
            hl = tg ? 18 : 14;
            sh = (fb.size() <= hl);
            h.typ = tg ? {fb[16], fb[17]} : {fb[12], fb[13]};
            h.tci = tg ? {fb[14], fb[15]} : 16'h0;
        end
        hl = tg ? 18 : 14;
        h.vlan = tg;
        if (sh) begin
            short_exp = short_exp + 1;
            return;
        end
        h.dst = v.dst; h.src = v.src; h.fid = fid_next;
        hq.push_back(h);
        for (int i = hl; i < fb.size(); i++) begin
            p.d = fb[i]; p.last = (i == fb.size() - 1); p.fid = fid_next;
            pq.push_back(p);
        end
        fid_next = fid_next + 1;
    endtask

    task automatic send(input bit thr, input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (thr) while ($urandom_range(1, 0) == 0) begin
                tvalid = 1'b0;
                @(posedge clk); #1;
            end
            tdata = fb[i]; tlast = (i == fb.size() - 1); tvalid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 2000 && !acc; k++) begin
                @(negedge clk);
                acc = s_rdy;
                if (acc && i == 0) t_first = cyc;
                if (acc) t_last = cyc;
                @(posedge clk); #1;
            end
            if (!acc) begin
                nchk = nchk + 1; nfail = nfail + 1;
                $display("FAIL send_timeout: byte %0d not accepted, required accept", i);
                tvalid = 1'b0;
                return;
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 5000 && (hq.size() != 0 || pq.size() != 0); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_left", 128'(hq.size() + pq.size()), 128'd0);
        chk("err_short_count", 128'(err_cnt), 128'(short_exp));
    endtask

    vec_t tbl[10];
    vec_t v;
    int first_acc;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(48'h020000000001, 48'h020000000002, 16'h0800, 0, 16'h0, 16'h0, 3, 8'h11, 0, 1, 16'h0800, 0, 16'h0, 0);
        tbl[1] = mk(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h8100, 1, 16'hA00F, 16'h0806, 4, 8'h05, 0, 1, 16'h0806, 1, 16'hA00F, 0);
        tbl[2] = mk(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h8100, 1, 16'hA00F, 16'h0806, 4, 8'h05, 0, 0, 16'h8100, 0, 16'h0, 0);
        tbl[3] = mk(48'hFFFFFFFFFFFF, 48'h00AABBCCDDEE, 16'h8100, 1, 16'h0123, 16'h8100, 6, 8'h21, 0, 1, 16'h8100, 1, 16'h0123, 0);
        tbl[4] = mk(48'h111111111111, 48'h222222222222, 16'h0800, 0, 16'h0, 16'h0, 0, 8'h00, 10, 1, 16'h0, 0, 16'h0, 1);
        tbl[5] = mk(48'h333333333333, 48'h444444444444, 16'h0800, 0, 16'h0, 16'h0, 0, 8'h00, 0, 1, 16'h0, 0, 16'h0, 1);
        tbl[6] = mk(48'h555555555555, 48'h666666666666, 16'h86DD, 0, 16'h0, 16'h0, 1, 8'h5A, 0, 1, 16'h86DD, 0, 16'h0, 0);
        tbl[7] = mk(48'h777777777777, 48'h888888888888, 16'h8100, 1, 16'h0FFF, 16'h0800, 0, 8'h00, 0, 1, 16'h0, 0, 16'h0, 1);
        tbl[8] = mk(48'h0123456789AB, 48'hCDEF01234567, 16'h8100, 1, 16'hE123, 16'h0800, 64, 8'h03, 0, 1, 16'h0800, 1, 16'hE123, 0);
        tbl[9] = mk(48'h9A9B9C9D9E9F, 48'hA1A2A3A4A5A6, 16'h0806, 0, 16'h0, 16'h0, 2, 8'h77, 0, 0, 16'h0806, 0, 16'h0, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_tready", 128'(s_rdy), 128'd1);
        chk("rst_hdr_valid", 128'(hv), 128'd0);
        chk("rst_hdr_fields", {hd, hs, ht, vp, htci}, 128'd0);
        chk("rst_axis", {axv, axd, axl, err}, 128'd0);
        @(posedge clk); #1;

        // Table: untagged, tagged, tag disabled, double tag, short frames, minimal payload
        for (int i = 0; i < 10; i++) begin
            sel = ~tbl[i].en;
            build(tbl[i]);
            push_exp(tbl[i], 1'b1);
            send(1'b0, fb.size());
            drain();
        end
        sel = 1'b0;

        // Back-to-back zero-gap frames: exactly one idle input cycle per frame
        v = mk(48'h020000000011, 48'h020000000022, 16'h0800, 0, 16'h0, 16'h0, 5, 8'h09, 0, 1, 16'h0, 0, 16'h0, 0);
        build(v); push_exp(v, 1'b0); send(1'b0, fb.size());
        first_acc = t_first;
        v.seed = 8'h0D;
        build(v); push_exp(v, 1'b0); send(1'b0, fb.size());
        chk("b2b_cycles", 128'(t_last - first_acc), 128'd39);
        drain();

        // The header is held under backpressure, and no payload goes out before the handshake
        hdr_rdy = 1'b0;
        v = mk(48'h02000000000A, 48'h02000000000B, 16'h0800, 0, 16'h0, 16'h0, 5, 8'h31, 0, 1, 16'h0, 0, 16'h0, 0);
        build(v); push_exp(v, 1'b0);
        fork
            send(1'b0, fb.size());
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (hv) break;
                end
                for (int k = 0; k < 10; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("hdr_backpressure", {hv, s_rdy, axv, hd, hs, ht},
                        {1'b1, 1'b0, 1'b0, 48'h02000000000A, 48'h02000000000B, 16'h0800});
                end
                @(posedge clk); #1;
                hdr_rdy = 1'b1;
            end
        join
        drain();

        // Random throttling, mixed tagging, payload lengths 1-64
        rnd = 1'b1;
        for (int f = 0; f < 200; f++) begin
            v.dst = {16'($urandom), $urandom};
            v.src = {16'($urandom), $urandom};
            v.tag = 1'($urandom_range(1, 0));
            v.t12 = v.tag ? 16'h8100 : (($urandom_range(1, 0) == 1) ? 16'h0800 : 16'h0806);
            v.tci = 16'($urandom);
            v.inner = ($urandom_range(3, 0) == 0) ? 16'h8100 : 16'h86DD;
            v.plen = $urandom_range(64, 1);
            v.seed = 8'($urandom_range(255, 1));
            v.trunc = 0; v.en = 1'b1;
            build(v); push_exp(v, 1'b0); send(1'b1, fb.size());
        end
        drain();
        rnd = 1'b0;

        // Reset while payload byte 5 is on the input
        mon_off = 1'b1;
        v = mk(48'h020000000077, 48'h020000000088, 16'h0800, 0, 16'h0, 16'h0, 10, 8'h13, 0, 1, 16'h0, 0, 16'h0, 0);
        build(v);
        send(1'b0, 19);
        tdata = fb[19]; tlast = 1'b0; tvalid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tvalid = 1'b0;
        @(negedge clk);
        chk("midrst_hdr", {hv, hd, hs, ht, vp, htci}, 128'd0);
        chk("midrst_axis", {axv, axd, axl, err, s_rdy}, 128'd1);
        hq.delete(); pq.delete();
        mon_off = 1'b0;
        @(posedge clk); #1;
        build(tbl[1]); push_exp(tbl[1], 1'b1); send(1'b0, fb.size());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
